skin_mask_bbox: RTL

Pixel-stream stage directly downstream of the camera capture block. It consumes the RGB565 pixel stream (vsync/href/valid/data) and converts each pixel to Cb/Cr through a 3-stage pipeline. It thresholds Cb/Cr into a 1-bit skin mask, tagged with x/y coordinates. Per frame it also accumulates the skin-pixel bounding box and pixel count, then latches them at the next frame start for the gesture classifier.

---
 rtl/skin_mask_bbox.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/skin_mask_bbox.sv
// skin_mask_bbox: RGB565 camera stream -> Cb/Cr skin mask with per-frame bounding box and count.
// Latency: mask 3 cycles after the input strobe; box/count/frame_done 1 cycle after vsync is sampled high.
// Backpressure: none, one pixel per cycle; pixels outside H_ACT x V_ACT are dropped at the input.
// Ports: cam_pclk/rst clock and async active-high reset; cmos_frame_* camera stream in;
//        mask_valid/mask_data/mask_x/mask_y per-pixel mask out; box_*/skin_cnt/box_valid
//        latched result of the previous frame; frame_done pulses when those update.
module skin_mask_bbox #(
  parameter logic [7:0] CB_MIN = 8'd77,
  parameter logic [7:0] CB_MAX = 8'd127,
  parameter logic [7:0] CR_MIN = 8'd133,
  parameter logic [7:0] CR_MAX = 8'd173,
  parameter int         H_ACT  = 640,
  parameter int         V_ACT  = 480
) (
  input  logic        cam_pclk,
  input  logic        rst,
  input  logic        cmos_frame_vsync,
  input  logic        cmos_frame_href,
  input  logic        cmos_frame_valid,
  input  logic [15:0] cmos_frame_data,
  output logic        mask_valid,
  output logic        mask_data,
  output logic [9:0]  mask_x,
  output logic [9:0]  mask_y,
  output logic [9:0]  box_x_min,
  output logic [9:0]  box_x_max,
  output logic [9:0]  box_y_min,
  output logic [9:0]  box_y_max,
  output logic [18:0] skin_cnt,
  output logic        box_valid,
  output logic        frame_done
);

  localparam logic [10:0] H_LIM = 11'(H_ACT);
  localparam logic [10:0] V_LIM = 11'(V_ACT);

  logic        vsync_d_q, href_d_q;
  logic [10:0] x_q, x_d, y_q, y_d;
  logic        vs_rise, href_fall, issue;
  logic [7:0]  r8, g8, b8;

  logic        s1_vld_q;
  logic [9:0]  s1_x_q, s1_y_q;
  logic [15:0] p43r_q, p85g_q, p128b_q, p128r_q, p107g_q, p21b_q;

  logic        s2_vld_q;
  logic [9:0]  s2_x_q, s2_y_q;
  logic [7:0]  cb_q, cr_q;
  logic [15:0] cb_sum, cr_sum;

  logic        s3_vld_q, s3_msk_q;
  logic [9:0]  s3_x_q, s3_y_q;

  logic [9:0]  acc_x_min_q, acc_x_max_q, acc_y_min_q, acc_y_max_q;
  logic [9:0]  acc_x_min_d, acc_x_max_d, acc_y_min_d, acc_y_max_d;
  logic [18:0] acc_cnt_q, acc_cnt_d;
  logic [9:0]  m_x_min, m_x_max, m_y_min, m_y_max;
  logic [18:0] m_cnt;

  logic [9:0]  box_x_min_q, box_x_max_q, box_y_min_q, box_y_max_q;
  logic [9:0]  box_x_min_d, box_x_max_d, box_y_min_d, box_y_max_d;
  logic [18:0] skin_cnt_q, skin_cnt_d;
  logic        box_valid_q, box_valid_d, frame_done_q, frame_done_d;

  assign vs_rise   = cmos_frame_vsync & ~vsync_d_q;
  assign href_fall = href_d_q & ~cmos_frame_href;
  assign issue     = cmos_frame_valid && (x_q < H_LIM) && (y_q < V_LIM);

  // Replicate the MSBs into the new LSBs so full-scale 5/6-bit maps to 255.
  assign r8 = {cmos_frame_data[15:11], cmos_frame_data[15:13]};
  assign g8 = {cmos_frame_data[10:5],  cmos_frame_data[10:9]};
  assign b8 = {cmos_frame_data[4:0],   cmos_frame_data[4:2]};

  // Counters saturate so an over-long line/frame cannot wrap back into the active window.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (!cmos_frame_href) begin
      x_d = '0;
    end else if (cmos_frame_valid && (x_q != 11'h7FF)) begin
      x_d = x_q + 11'd1;
    end
    if (vs_rise) begin
      y_d = '0;
    end else if (href_fall && (y_q != 11'h7FF)) begin
      y_d = y_q + 11'd1;
    end
  end

  // The offset 32768 keeps both sums positive over the whole RGB cube, so
  // modulo-2^16 arithmetic gives the exact result.
  assign cb_sum = 16'd32768 - p43r_q - p85g_q + p128b_q;
  assign cr_sum = 16'd32768 + p128r_q - p107g_q - p21b_q;

  // Merge the pixel leaving stage 3 into the running accumulators; the merged
  // value is what gets latched on a frame close so a same-cycle pixel is kept.
  always_comb begin
    m_x_min = acc_x_min_q;
    m_x_max = acc_x_max_q;
    m_y_min = acc_y_min_q;
    m_y_max = acc_y_max_q;
    m_cnt   = acc_cnt_q;
    if (s3_vld_q && s3_msk_q) begin
      if (s3_x_q < acc_x_min_q) m_x_min = s3_x_q;
      if (s3_x_q > acc_x_max_q) m_x_max = s3_x_q;
      if (s3_y_q < acc_y_min_q) m_y_min = s3_y_q;
      if (s3_y_q > acc_y_max_q) m_y_max = s3_y_q;
      if (acc_cnt_q != '1)      m_cnt   = acc_cnt_q + 19'd1;
    end

    acc_x_min_d  = m_x_min;
    acc_x_max_d  = m_x_max;
    acc_y_min_d  = m_y_min;
    acc_y_max_d  = m_y_max;
    acc_cnt_d    = m_cnt;
    box_x_min_d  = box_x_min_q;
    box_x_max_d  = box_x_max_q;
    box_y_min_d  = box_y_min_q;
    box_y_max_d  = box_y_max_q;
    skin_cnt_d   = skin_cnt_q;
    box_valid_d  = box_valid_q;
    frame_done_d = 1'b0;

    if (vs_rise) begin
      acc_x_min_d  = 10'h3FF;
      acc_x_max_d  = '0;
      acc_y_min_d  = 10'h3FF;
      acc_y_max_d  = '0;
      acc_cnt_d    = '0;
      frame_done_d = 1'b1;
      box_valid_d  = (m_cnt != '0);
      skin_cnt_d   = m_cnt;
      // An empty frame reports a zero box rather than the 1023/0 init values.
      box_x_min_d  = box_valid_d ? m_x_min : '0;
      box_x_max_d  = box_valid_d ? m_x_max : '0;
      box_y_min_d  = box_valid_d ? m_y_min : '0;
      box_y_max_d  = box_valid_d ? m_y_max : '0;
    end
  end

  always_ff @(posedge cam_pclk or posedge rst) begin
    if (rst) begin
      vsync_d_q <= 1'b0;
      href_d_q  <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      s1_vld_q  <= 1'b0;
      s1_x_q    <= '0;
      s1_y_q    <= '0;
      p43r_q    <= '0;
      p85g_q    <= '0;
      p128b_q   <= '0;
      p128r_q   <= '0;
      p107g_q   <= '0;
      p21b_q    <= '0;
      s2_vld_q  <= 1'b0;
      s2_x_q    <= '0;
      s2_y_q    <= '0;
      cb_q      <= '0;
      cr_q      <= '0;
      s3_vld_q  <= 1'b0;
      s3_msk_q  <= 1'b0;
      s3_x_q    <= '0;
      s3_y_q    <= '0;
    end else begin
      vsync_d_q <= cmos_frame_vsync;
      href_d_q  <= cmos_frame_href;
      x_q       <= x_d;
      y_q       <= y_d;
      // Stage 1: coordinate tag and weighted colour products.
      s1_vld_q  <= issue;
      s1_x_q    <= x_q[9:0];
      s1_y_q    <= y_q[9:0];
      p43r_q    <= 16'd43 * {8'd0, r8};
      p85g_q    <= 16'd85 * {8'd0, g8};
      p128b_q   <= {1'b0, b8, 7'd0};
      p128r_q   <= {1'b0, r8, 7'd0};
      p107g_q   <= 16'd107 * {8'd0, g8};
      p21b_q    <= 16'd21 * {8'd0, b8};
      // Stage 2: chroma sums, keep the integer part.
      s2_vld_q  <= s1_vld_q;
      s2_x_q    <= s1_x_q;
      s2_y_q    <= s1_y_q;
      cb_q      <= 8'(cb_sum >> 8);
      cr_q      <= 8'(cr_sum >> 8);
      // Stage 3: window threshold.
      s3_vld_q  <= s2_vld_q;
      s3_msk_q  <= (cb_q >= CB_MIN) && (cb_q <= CB_MAX) &&
                   (cr_q >= CR_MIN) && (cr_q <= CR_MAX);
      s3_x_q    <= s2_x_q;
      s3_y_q    <= s2_y_q;
    end
  end

  always_ff @(posedge cam_pclk or posedge rst) begin
    if (rst) begin
      acc_x_min_q  <= 10'h3FF;
      acc_x_max_q  <= '0;
      acc_y_min_q  <= 10'h3FF;
      acc_y_max_q  <= '0;
      acc_cnt_q    <= '0;
      box_x_min_q  <= '0;
      box_x_max_q  <= '0;
      box_y_min_q  <= '0;
      box_y_max_q  <= '0;
      skin_cnt_q   <= '0;
      box_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      acc_x_min_q  <= acc_x_min_d;
      acc_x_max_q  <= acc_x_max_d;
      acc_y_min_q  <= acc_y_min_d;
      acc_y_max_q  <= acc_y_max_d;
      acc_cnt_q    <= acc_cnt_d;
      box_x_min_q  <= box_x_min_d;
      box_x_max_q  <= box_x_max_d;
      box_y_min_q  <= box_y_min_d;
      box_y_max_q  <= box_y_max_d;
      skin_cnt_q   <= skin_cnt_d;
      box_valid_q  <= box_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign mask_valid = s3_vld_q;
  assign mask_data  = s3_msk_q;
  assign mask_x     = s3_x_q;
  assign mask_y     = s3_y_q;
  assign box_x_min  = box_x_min_q;
  assign box_x_max  = box_x_max_q;
  assign box_y_min  = box_y_min_q;
  assign box_y_max  = box_y_max_q;
  assign skin_cnt   = skin_cnt_q;
  assign box_valid  = box_valid_q;
  assign frame_done = frame_done_q;

endmodule
